// File: rtl/cdc_2phase_rsp_pkg.sv
// Shared constants for the two-phase CDC responder.
// Holds the default synchronizer depth used by the top and its synchronizer.
package cdc_2phase_rsp_pkg;

  localparam int unsigned CDC_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/cdc_2phase_rsp_sync.sv
// Multi-flop level synchronizer, reset value 0, with synchronous clear.
// Latency STAGES edges; no backpressure (level signal).
module cdc_2phase_rsp_sync
  import cdc_2phase_rsp_pkg::*;
#(
  parameter int unsigned STAGES = CDC_SYNC_STAGES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  (* dont_touch = "true", async_reg = "true" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else if (clr_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_2phase_rsp.sv
// Two-phase (toggle) request/response responder: presents one remote request locally, returns one response.
// Request visible SYNC_STAGES+1 edges after the toggle; local valid/ready holds until accepted, one transaction outstanding.
module cdc_2phase_rsp
  import cdc_2phase_rsp_pkg::*;
#(
  parameter type         REQ_T       = logic,
  parameter type         RSP_T       = logic,
  parameter int unsigned SYNC_STAGES = CDC_SYNC_STAGES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic async_req_i,
  input  REQ_T async_req_data_i,
  output logic async_ack_o,
  output RSP_T async_rsp_data_o,
  output REQ_T req_data_o,
  output logic req_valid_o,
  input  logic req_ready_i,
  input  RSP_T rsp_data_i,
  input  logic rsp_valid_i,
  output logic rsp_ready_o,
  output logic busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   ack_q, ack_d;
  RSP_T   rsp_q, rsp_d;
  REQ_T   req_d;
  (* dont_touch = "true", async_reg = "true" *) REQ_T req_q;

  logic req_sync;
  logic pending;

  cdc_2phase_rsp_sync #(
    .STAGES (SYNC_STAGES)
  ) i_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .d_i    (async_req_i),
    .q_o    (req_sync)
  );

  // A level mismatch between the synchronized request and our ack is a new request.
  assign pending = (req_sync != ack_q);

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    rsp_d       = rsp_q;
    req_d       = req_q;
    req_valid_o = 1'b0;
    rsp_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending) begin
          req_d   = async_req_data_i;
          state_d = REQ;
        end
      end
      REQ: begin
        req_valid_o = 1'b1;
        if (req_ready_i) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        rsp_ready_o = 1'b1;
        if (rsp_valid_i) begin
          rsp_d   = rsp_data_i;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rsp_q   <= '0;
      req_q   <= '0;
    end else if (clr_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rsp_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
      req_q   <= req_d;
    end
  end

  assign async_ack_o      = ack_q;
  assign async_rsp_data_o = rsp_q;
  assign req_data_o       = req_q;
  assign busy_o           = (state_q != IDLE);

endmodule
